// File: rtl/fpu_zhinx_requester.sv
// fpu_zhinx_requester: queues Zhinx FPU requests and issues them one at a time on a start/done handshake.
// Define FPU_REQ_TIMEOUT_EN to enable a watchdog that aborts an FPU op stuck in WAIT.
module fpu_zhinx_requester #(
   parameter int DEPTH = 2,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int WORD_W = 32,
   parameter int OP_W = 4
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   req_op,
   input  logic [WORD_W-1:0] req_a,
   input  logic [WORD_W-1:0] req_b,
   input  logic [4:0]        req_rd,
   output logic              fpu_start,
   output logic [OP_W-1:0]   fpu_operation,
   output logic [WORD_W-1:0] fpu_a,
   output logic [WORD_W-1:0] fpu_b,
   input  logic              fpu_done,
   input  logic [WORD_W-1:0] fpu_out,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [WORD_W-1:0] wb_data,
   output logic [4:0]        wb_rd,
   output logic              wb_err,
   output logic              busy
);
   localparam logic [OP_W-1:0] FPU_HALF_ADD = '0;
   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
      $error("fpu_zhinx_requester: DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 2");
   end

   typedef enum logic {IDLE, WAIT} state_t;
   state_t state, state_n;

   logic [OP_W-1:0]   op_q [DEPTH];
   logic [WORD_W-1:0] a_q  [DEPTH];
   logic [WORD_W-1:0] b_q  [DEPTH];
   logic [4:0]        rd_q [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic empty, push, pop, slot_free, abort, issue_ok;

   assign empty     = count == '0;
   assign req_ready = count != (AW+1)'(DEPTH);
   assign push      = req_valid && req_ready;
   assign slot_free = !wb_valid || wb_ready;
   assign pop       = (fpu_start && fpu_done) || abort;
   assign busy      = !empty || wb_valid;

`ifdef FPU_REQ_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   logic [CW-1:0] wait_cnt;
   logic cool;
   assign abort    = state == WAIT && !fpu_done && wait_cnt == CW'(TIMEOUT_CYCLES - 1);
   assign issue_ok = !cool;
   // cool keeps start low for one cycle after an abort so the FPU sees the op end
   always_ff @(posedge CLK, negedge nRST)
      if (!nRST) begin
         wait_cnt <= '0;
         cool     <= 1'b0;
      end else begin
         wait_cnt <= (state == WAIT && !pop) ? wait_cnt + 1'b1 : '0;
         cool     <= abort;
      end
`else
   assign abort    = 1'b0;
   assign issue_ok = 1'b1;
`endif

   always_ff @(posedge CLK)
      if (push) begin
         op_q[wr_ptr] <= req_op;
         a_q[wr_ptr]  <= req_a;
         b_q[wr_ptr]  <= req_b;
         rd_q[wr_ptr] <= req_rd;
      end

   always_ff @(posedge CLK, negedge nRST)
      if (!nRST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      end

   always_ff @(posedge CLK, negedge nRST)
      if (!nRST) state <= IDLE;
      else state <= state_n;

   always_comb begin
      state_n = state;
      if (state == IDLE && fpu_start && !fpu_done) state_n = WAIT;
      else if (state == WAIT && pop) state_n = IDLE;
   end

   always_comb begin
      fpu_start     = state == WAIT || (!empty && slot_free && issue_ok);
      fpu_operation = empty ? FPU_HALF_ADD : op_q[rd_ptr];
      fpu_a         = empty ? '0 : a_q[rd_ptr];
      fpu_b         = empty ? '0 : b_q[rd_ptr];
   end

   // a completion on the same edge as a drain replaces the outgoing result
   always_ff @(posedge CLK, negedge nRST)
      if (!nRST) begin
         wb_valid <= 1'b0;
         wb_data  <= '0;
         wb_rd    <= '0;
         wb_err   <= 1'b0;
      end else if (pop) begin
         wb_valid <= 1'b1;
         wb_data  <= abort ? '0 : fpu_out;
         wb_rd    <= rd_q[rd_ptr];
         wb_err   <= abort;
      end else if (wb_ready) begin
         wb_valid <= 1'b0;
      end
endmodule

// File: tb/tb_fpu_zhinx_requester.sv
// tb_fpu_zhinx_requester: scoreboard bench with a stub FPU whose done latency is programmable.
module tb_fpu_zhinx_requester;
   localparam logic [3:0] OP_ADD = 4'd0, OP_MUL = 4'd2, OP_FEQ = 4'd9;

   logic        CLK = 1'b0, nRST = 1'b0;
   logic        req_valid = 1'b0, req_ready;
   logic [3:0]  req_op = '0;
   logic [31:0] req_a = '0, req_b = '0;
   logic [4:0]  req_rd = '0;
   logic        fpu_start, fpu_done;
   logic [3:0]  fpu_operation;
   logic [31:0] fpu_a, fpu_b, fpu_out;
   logic        wb_valid, wb_ready = 1'b1, wb_err, busy;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;

   int vectors = 0, miscompares = 0;
   int done_delay = 0, wcnt = 0;
   logic [37:0] sb[$];
   logic [37:0] hold_val, exp_v;
   logic hold_prev = 1'b0;

   fpu_zhinx_requester #(.DEPTH(2), .TIMEOUT_CYCLES(8), .WORD_W(32), .OP_W(4)) dut (
      .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .fpu_start(fpu_start),
      .fpu_operation(fpu_operation), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_done(fpu_done),
      .fpu_out(fpu_out), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
      .wb_rd(wb_rd), .wb_err(wb_err), .busy(busy));

   always #5 CLK = ~CLK;

   // stub FPU: known half-precision vectors, otherwise an asymmetric mix of the operands
   function automatic logic [31:0] model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
      if (op == OP_ADD && a == 32'h3C00 && b == 32'h3C00) return 32'h4000;
      if (op == OP_MUL && a == 32'h4000 && b == 32'h4200) return 32'h4600;
      if (op == OP_FEQ) return {31'd0, a == b};
      return a ^ {b[15:0], b[31:16]} ^ {28'd0, op};
   endfunction

   assign fpu_out  = model(fpu_operation, fpu_a, fpu_b);
   assign fpu_done = wcnt >= done_delay;

   always @(posedge CLK or negedge nRST)
      if (!nRST) wcnt <= 0;
      else wcnt <= (fpu_start && !fpu_done) ? wcnt + 1 : 0;

   always @(negedge CLK) begin
      if (nRST && wb_valid && !wb_ready) begin
         if (hold_prev) begin
            vectors++;
            if ({wb_err, wb_rd, wb_data} !== hold_val) begin
               miscompares++;
               $display("FAIL wb_hold: got %h want %h", {wb_err, wb_rd, wb_data}, hold_val);
            end
         end
         hold_prev = 1'b1;
         hold_val = {wb_err, wb_rd, wb_data};
      end else hold_prev = 1'b0;
      if (nRST && wb_valid && wb_ready) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL wb_spurious: got %h want no result", {wb_err, wb_rd, wb_data});
         end else begin
            exp_v = sb.pop_front();
            if ({wb_err, wb_rd, wb_data} !== exp_v) begin
               miscompares++;
               $display("FAIL wb_result: got %h want %h", {wb_err, wb_rd, wb_data}, exp_v);
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic push(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] rd, logic err);
      int n = 0;
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
      while (!req_ready && n < 50) begin tick(); n++; end
      if (n == 50) begin
         miscompares++; vectors++;
         $display("FAIL push_timeout: got req_ready=0 want 1");
      end
      sb.push_back(err ? {1'b1, rd, 32'd0} : {1'b0, rd, model(op, a, b)});
      tick();
      req_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      vectors++;
      if ({fpu_start, fpu_operation, fpu_a, fpu_b, wb_valid, wb_data, wb_rd, wb_err, busy, req_ready} !== {1'b0, OP_ADD, 64'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL reset_state: start=%b op=%h a=%h b=%h wbv=%b wbd=%h rd=%h err=%b busy=%b rdy=%b", fpu_start, fpu_operation, fpu_a, fpu_b, wb_valid, wb_data, wb_rd, wb_err, busy, req_ready);
      end
      tick(); tick();
      nRST = 1'b1;
      tick();
   endtask

   task automatic test_latency();
      wb_ready = 1'b1; done_delay = 0;
      req_valid = 1'b1; req_op = OP_ADD; req_a = 32'h3C00; req_b = 32'h3C00; req_rd = 5'd5;
      sb.push_back({1'b0, 5'd5, 32'h4000});
      tick();
      req_valid = 1'b0;
      vectors++;
      if ({fpu_start, wb_valid} !== 2'b10) begin
         miscompares++; $display("FAIL lat_n1: got start=%b wbv=%b want 1 0", fpu_start, wb_valid);
      end
      tick();
      vectors++;
      if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'h4000, 5'd5}) begin
         miscompares++; $display("FAIL lat_n2: got v=%b d=%h rd=%0d want 1 4000 5", wb_valid, wb_data, wb_rd);
      end
      tick();
      vectors++;
      if (wb_valid !== 1'b0) begin
         miscompares++; $display("FAIL lat_fall: got wbv=%b want 0", wb_valid);
      end
   endtask

   task automatic test_back_to_back();
      req_valid = 1'b1; req_op = OP_MUL; req_a = 32'h4000; req_b = 32'h4200; req_rd = 5'd1;
      sb.push_back({1'b0, 5'd1, 32'h4600});
      tick();
      req_op = OP_FEQ; req_a = 32'h3C00; req_b = 32'h3C00; req_rd = 5'd2;
      sb.push_back({1'b0, 5'd2, 32'h1});
      vectors++;
      if (req_ready !== 1'b1) begin
         miscompares++; $display("FAIL b2b_ready: got %b want 1", req_ready);
      end
      tick();
      req_valid = 1'b0;
      vectors++;
      if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'h4600, 5'd1}) begin
         miscompares++; $display("FAIL b2b_first: got v=%b d=%h rd=%0d want 1 4600 1", wb_valid, wb_data, wb_rd);
      end
      tick();
      vectors++;
      if ({wb_valid, wb_data, wb_rd} !== {1'b1, 32'h1, 5'd2}) begin
         miscompares++; $display("FAIL b2b_second: got v=%b d=%h rd=%0d want 1 1 2", wb_valid, wb_data, wb_rd);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int n = 0;
      wb_ready = 1'b0;
      push(OP_ADD, 32'h1111, 32'h2222, 5'd11, 1'b0);
      push(OP_MUL, 32'h3333, 32'h4444, 5'd12, 1'b0);
      push(OP_FEQ, 32'h5555, 32'h5556, 5'd13, 1'b0);
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if ({req_ready, fpu_start, wb_valid, busy, wb_rd} !== {4'b0011, 5'd11}) begin
            miscompares++;
            $display("FAIL bp_full: got rdy=%b start=%b wbv=%b busy=%b rd=%0d want 0 0 1 1 11", req_ready, fpu_start, wb_valid, busy, wb_rd);
         end
         tick();
      end
      wb_ready = 1'b1;
      while (busy && n < 20) begin tick(); n++; end
      vectors++;
      if (busy !== 1'b0 || sb.size() != 0) begin
         miscompares++; $display("FAIL bp_drain: got busy=%b pending=%0d want 0 0", busy, sb.size());
      end
   endtask

   task automatic test_slow_fpu();
      done_delay = 3;
      push(OP_MUL, 32'h1234, 32'h0042, 5'd7, 1'b0);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if ({fpu_start, fpu_operation, fpu_a, fpu_b, wb_valid} !== {1'b1, OP_MUL, 32'h1234, 32'h0042, 1'b0}) begin
            miscompares++;
            $display("FAIL slow_hold%0d: got start=%b op=%h a=%h b=%h wbv=%b", i, fpu_start, fpu_operation, fpu_a, fpu_b, wb_valid);
         end
         tick();
      end
      vectors++;
      if ({wb_valid, wb_rd, fpu_start} !== {1'b1, 5'd7, 1'b0}) begin
         miscompares++; $display("FAIL slow_done: got v=%b rd=%0d start=%b want 1 7 0", wb_valid, wb_rd, fpu_start);
      end
      done_delay = 0;
      tick();
   endtask

   task automatic test_reset_mid();
      done_delay = 100;
      push(OP_ADD, 32'hAAAA, 32'h0001, 5'd3, 1'b0);
      push(OP_ADD, 32'hBBBB, 32'h0002, 5'd4, 1'b0);
      tick();
      #2 nRST = 1'b0;
      #1;
      vectors++;
      if ({fpu_start, fpu_operation, fpu_a, fpu_b, req_ready, busy, wb_valid} !== {1'b0, OP_ADD, 64'd0, 3'b100}) begin
         miscompares++;
         $display("FAIL rst_mid: got start=%b op=%h a=%h b=%h rdy=%b busy=%b wbv=%b", fpu_start, fpu_operation, fpu_a, fpu_b, req_ready, busy, wb_valid);
      end
      sb.delete();
      done_delay = 0;
      tick();
      nRST = 1'b1;
      tick(); tick();
      vectors++;
      if ({req_ready, busy, wb_valid, fpu_start} !== 4'b1000) begin
         miscompares++; $display("FAIL rst_release: got rdy=%b busy=%b wbv=%b start=%b", req_ready, busy, wb_valid, fpu_start);
      end
   endtask

`ifdef FPU_REQ_TIMEOUT_EN
   task automatic test_timeout();
      int n = 1;
      wb_ready = 1'b1; done_delay = 1000;
      push(OP_MUL, 32'h0BAD, 32'h0F00, 5'd20, 1'b1);
      vectors++;
      if (fpu_start !== 1'b1) begin
         miscompares++; $display("FAIL to_issue: got start=%b want 1", fpu_start);
      end
      push(OP_ADD, 32'h0123, 32'h0456, 5'd21, 1'b0);
      while (!wb_valid && n < 40) begin
         if (fpu_start) n++;
         tick();
      end
      vectors++;
      if ({n, wb_valid, wb_err, wb_data, wb_rd, fpu_start} !== {32'd9, 1'b1, 1'b1, 32'd0, 5'd20, 1'b0}) begin
         miscompares++;
         $display("FAIL to_abort: got cycles=%0d v=%b err=%b d=%h rd=%0d start=%b want 9 1 1 0 20 0", n, wb_valid, wb_err, wb_data, wb_rd, fpu_start);
      end
      done_delay = 0;
      tick();
      vectors++;
      if ({fpu_start, fpu_a} !== {1'b1, 32'h0123}) begin
         miscompares++; $display("FAIL to_next: got start=%b a=%h want 1 0123", fpu_start, fpu_a);
      end
      tick(); tick();
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_backpressure();
      test_slow_fpu();
      test_reset_mid();
`ifdef FPU_REQ_TIMEOUT_EN
      test_timeout();
`endif
      repeat (5) tick();
      vectors++;
      if (sb.size() != 0) begin
         miscompares++; $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/fpu_zhinx_requester.md
Name: fpu_zhinx_requester

Overview:
- Initiator side of the half-precision FPU start/done handshake. Sits between the integer pipeline's execute stage and the Zhinx FPU datapath.
- Buffers up to DEPTH operation requests and issues them one at a time on the FPU start/done interface. Holds operation and operands stable until done.
- Captures each result into a single writeback register drained by a valid/ready handshake.

Parameters:
- DEPTH, 2: request FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 64: watchdog limit in cycles; used only with FPU_REQ_TIMEOUT_EN.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- req_valid  in  1  pipeline request valid
- req_ready  out  1  request accepted on a cycle with req_valid&&req_ready
- req_op  in  fpu_operation_t  requested operation
- req_a  in  WORD_W  operand A (Zhinx register value)
- req_b  in  WORD_W  operand B
- req_rd  in  5  destination register tag
- fpu_start  out  1  FPU start
- fpu_operation  out  fpu_operation_t  operation to FPU
- fpu_a  out  WORD_W  operand A to FPU
- fpu_b  out  WORD_W  operand B to FPU
- fpu_done  in  1  FPU done; meaningful only while fpu_start=1
- fpu_out  in  WORD_W  FPU result
- wb_valid  out  1  result available
- wb_ready  in  1  consumer takes the result
- wb_data  out  WORD_W  result
- wb_rd  out  5  destination tag of the result
- wb_err  out  1  result is a timeout abort (always 0 without the macro)
- busy  out  1  FIFO non-empty, or wb_valid=1

Behaviour:
- Reset (async, nRST=0):
  - FIFO empty, pointers 0, state IDLE.
  - fpu_start=0, fpu_operation=FPU_HALF_ADD, fpu_a=fpu_b=0.
  - wb_valid=0, wb_data=0, wb_rd=0, wb_err=0, busy=0, req_ready=1.
  - Reset mid-operation discards all queued and in-flight work. The FPU sees start fall immediately.
- Request FIFO:
  - Push on req_valid&&req_ready.
  - req_ready = !full. It is registered-state only; a pop in the same cycle does not open a slot.
  - Full-while-popping still shows ready=0 that cycle.
  - Pointers wrap modulo DEPTH. Occupancy counter is 0..DEPTH.
  - No empty bypass: a request pushed in cycle N issues no earlier than cycle N+1.
- FPU outputs:
  - fpu_operation/fpu_a/fpu_b are driven from the FIFO head when non-empty.
  - When empty they are driven to FPU_HALF_ADD/0/0.
- FSM, two states: IDLE and WAIT.
  - slot_free = !wb_valid || wb_ready.
  - IDLE: fpu_start = !empty && slot_free.
    - Start with fpu_done=1 at the edge: completes the same cycle, stays IDLE.
    - Start with fpu_done=0: goes to WAIT.
  - WAIT: fpu_start=1 unconditionally. Operands held from the head, unchanged.
    - fpu_done=1 at the edge: completes, returns to IDLE.
    - wb_valid cannot rise while in WAIT, so start never drops before done.
- Completion edge:
  - Pop the head.
  - wb_data<=fpu_out, wb_rd<=head rd, wb_err<=0, wb_valid<=1.
  - Clear the wait counter.
- Writeback:
  - wb_valid falls on wb_valid&&wb_ready unless a completion occurs on the same edge; the new result then replaces it.
  - wb_data and wb_rd are stable while wb_valid&&!wb_ready.
- Latency and throughput:
  - Single-cycle FPU op: request in cycle N, wb_valid in cycle N+2.
  - Sustained 1 op/cycle when wb_ready=1.
- Ordering: results appear strictly in request order.
- fpu_done while fpu_start=0 is ignored.

Optional Feature:
- Macro: FPU_REQ_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle in WAIT without fpu_done.
  - On reaching TIMEOUT_CYCLES-1 with done still 0: pop the head, wb_valid<=1, wb_err<=1, wb_data<=0, wb_rd<=head rd, go to IDLE.
  - fpu_start is low for at least one cycle afterwards.
  - done on the limit cycle counts as a normal completion.
- Undefined: no counter; WAIT persists indefinitely; wb_err is tied 0.

Test Plan:
- Reset, then ADD a=0x3C00 b=0x3C00 rd=5, wb_ready=1 → fpu_start high in cycle N+1; wb_valid in cycle N+2 with wb_data=0x00004000, wb_rd=5, then falls.
- Back-to-back pushes MUL 0x4000*0x4200 (rd=1) then FEQ 0x3C00,0x3C00 (rd=2), wb_ready=1 → wb_data 0x00004600 then 0x00000001, in order, on consecutive cycles.
- wb_ready=0 with 3 pushes (DEPTH=2) → first result held stable; FIFO fills; req_ready=0; fpu_start=0. Raising wb_ready drains all three in order with no loss or duplication.
- Stub FPU with done low for 3 cycles → fpu_start plus unchanged operands for 4 cycles; result captured on the 4th; FSM traverses IDLE→WAIT→IDLE.
- Assert nRST during WAIT with 2 entries queued → all outputs at reset values asynchronously; after release req_ready=1, busy=0, no wb_valid.
- With FPU_REQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, done held 0 → after 8 WAIT cycles wb_valid=1, wb_err=1, wb_data=0; the next queued op then issues normally.
